truth_table_prober: RTL and testbench
=====================================

TRUTH_TABLE_PROBER -- requirements
Module: truth_table_prober

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles each input vector is held before probe_y is sampled.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port expected, input, 8 bits: golden truth table, bit i = expected y for vector i; captured on accepted start.
REQ-006 The block SHALL have ports probe_b, probe_a, probe_c, output, 1 bit each: vector driven to the 3-input combinational function under test.
REQ-007 The block SHALL have port probe_y, input, 1 bit: response of the function under test.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until DONE ends.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the sweep completes.
REQ-010 The block SHALL have port table_out, output, 8 bits: captured truth table, bit i = probe_y for vector i.
REQ-011 The block SHALL have port mismatch_mask, output, 8 bits: table_out XOR captured expected, valid from done onward.
REQ-012 The block SHALL have port mismatch, output, 1 bit: OR-reduction of mismatch_mask.

Function
REQ-013 Vector index i (3 bits) SHALL map as {probe_b, probe_a, probe_c} = i, i.e. b is MSB and c is LSB.
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> SETTLE, with i=0, settle counter=0, expected captured, table_out cleared to 0.
- SETTLE: count SETTLE_CYCLES cycles, then -> SAMPLE.
- SAMPLE: write table_out[i] <= probe_y; i=7 -> DONE, otherwise i++ and -> SETTLE.
- DONE: done=1 and mismatch_mask registered, for one cycle; then -> IDLE.
REQ-015 In IDLE, probe outputs SHALL be 0, and they SHALL equal i in SETTLE and SAMPLE.
REQ-016 If start is sampled high at cycle 0, done SHALL be high at cycle 8*(SETTLE_CYCLES+1)+1; with the default this is cycle 17.
REQ-017 start SHALL be ignored while busy, and a start held high through DONE SHALL begin a new sweep from IDLE on the following cycle.
REQ-018 table_out, mismatch_mask and mismatch SHALL hold their values after DONE until the next accepted start.
REQ-019 probe_y SHALL be sampled only in SAMPLE, and changes in other states SHALL have no effect.
REQ-020 Index increment SHALL never wrap during a sweep, because i=7 always exits to DONE.

Reset
REQ-021 Asserting reset in any state, including mid-sweep, SHALL immediately force IDLE, i=0, counter=0, probes=000, busy=0, done=0, table_out=0, mismatch_mask=0, mismatch=0, and captured expected=0.
REQ-022 After reset deasserts, the first accepted start SHALL begin a complete sweep from vector 0.

Structure
REQ-023 A shared package truth_probe_pkg SHALL hold the state enum, the vector-index width (3), and the table width (8).
REQ-024 The settle counter SHALL be a sub-module settle_timer (inputs clk, reset, clear, enable; output expired), and all other logic SHALL stay in truth_table_prober.

Verification
REQ-025 The bench SHALL connect probe_y = probe_a & probe_b, set expected=8'hC0, and pulse start -> done at cycle 17, table_out=8'hC0, mismatch=0.
REQ-026 The bench SHALL connect probe_y = probe_a ^ probe_b, set expected=8'h3C, and pulse start -> table_out=8'h3C, mismatch_mask=8'h00.
REQ-027 The bench SHALL tie probe_y to 0, set expected=8'hFF, and pulse start -> table_out=8'h00, mismatch_mask=8'hFF, mismatch=1.
REQ-028 The bench SHALL assert reset at cycle 7 of a sweep -> all outputs 0 immediately; a new start then gives a correct full table with no residue.
REQ-029 The bench SHALL pulse start again while busy -> no effect on i or timing, and done occurs exactly once at cycle 17.
REQ-030 With SETTLE_CYCLES=3 and a function with one-cycle registered delay from probes to probe_y, the bench SHALL check -> correct table and done at cycle 33.

Source files
------------

// File: rtl/truth_probe_pkg.sv
// Shared types and sizes for the truth-table prober: FSM states, vector index and table widths.
// Pure declarations; no logic, no latency, no flow control.
package truth_probe_pkg;

  localparam int IDX_W = 3;
  localparam int TBL_W = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TBL_W-1:0] tbl_t;

  localparam idx_t IDX_LAST = idx_t'(TBL_W - 1);

endpackage

// File: rtl/truth_table_prober_if.sv
// Control, result and probe signals of the prober; the slave side is the prober itself.
// Plain wires; start is only honoured while the prober is idle (no handshake beyond busy).
interface truth_table_prober_if;
  import truth_probe_pkg::*;

  logic start;
  tbl_t expected;
  logic probe_a;
  logic probe_b;
  logic probe_c;
  logic probe_y;
  logic busy;
  logic done;
  tbl_t table_out;
  tbl_t mismatch_mask;
  logic mismatch;

  modport master (
    output start, expected, probe_y,
    input  probe_a, probe_b, probe_c, busy, done, table_out, mismatch_mask, mismatch
  );

  modport slave (
    input  start, expected, probe_y,
    output probe_a, probe_b, probe_c, busy, done, table_out, mismatch_mask, mismatch
  );

endinterface

// File: rtl/truth_table_prober_settle_timer.sv
// Counts CYCLES enabled cycles after a clear; expired is high during the last of them.
// No flow control; clear wins over enable and the count saturates at the last value.
module settle_timer
  import truth_probe_pkg::*;
#(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_prober.sv
// Sweeps all 8 input vectors of a 3-input function, records its truth table and diffs it against a golden one.
// Done 8*(SETTLE_CYCLES+1)+1 cycles after start; start is ignored while busy.
module truth_table_prober
  import truth_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset,
  truth_table_prober_if.slave pif
);

  state_e state_q, state_d;
  idx_t   idx_q,   idx_d;
  tbl_t   exp_q,   exp_d;
  tbl_t   table_q, table_d;
  tbl_t   mask_q,  mask_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;
  logic probing;

  // Timer runs only inside SETTLE, so every vector gets a fresh settle window.
  assign tmr_en    = (state_q == SETTLE);
  assign tmr_clear = (state_q != SETTLE);

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    table_d = table_q;
    mask_d  = mask_q;

    case (state_q)
      IDLE: begin
        if (pif.start) begin
          state_d = SETTLE;
          idx_d   = '0;
          exp_d   = pif.expected;
          table_d = '0;
          mask_d  = '0;
        end
      end
      SETTLE: begin
        if (tmr_expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = pif.probe_y;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          mask_d  = table_d ^ exp_q;
        end else begin
          idx_d   = idx_q + idx_t'(1);
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mask_q  <= mask_d;
    end
  end

  assign probing           = (state_q == SETTLE) || (state_q == SAMPLE);
  assign pif.probe_b       = probing & idx_q[2];
  assign pif.probe_a       = probing & idx_q[1];
  assign pif.probe_c       = probing & idx_q[0];
  assign pif.busy          = (state_q != IDLE);
  assign pif.done          = (state_q == DONE);
  assign pif.table_out     = table_q;
  assign pif.mismatch_mask = mask_q;
  assign pif.mismatch      = |mask_q;

endmodule

// File: tb/tb_truth_table_prober.sv
// Bench for truth_table_prober: two instances (settle 1 with selectable function, settle 3 with a registered function).
// A timeline model checks every cycle; directed sweeps pin the model with literal results.
module tb_truth_table_prober;
  import truth_probe_pkg::*;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic reset;
  int   fsel = 0;
  int   nchk = 0;
  int   nerr = 0;
  logic y1 = 1'b0;

  always #5 clk = ~clk;

  truth_table_prober_if if0 ();
  truth_table_prober_if if1 ();

  truth_table_prober #(.SETTLE_CYCLES(S0)) dut0 (.clk(clk), .reset(reset), .pif(if0));
  truth_table_prober #(.SETTLE_CYCLES(S1)) dut1 (.clk(clk), .reset(reset), .pif(if1));

  assign if0.probe_y = (fsel == 0) ? (if0.probe_a & if0.probe_b) :
                       (fsel == 1) ? (if0.probe_a ^ if0.probe_b) : 1'b0;

  always @(posedge clk) y1 <= (if1.probe_b & ~if1.probe_c) | if1.probe_a;
  assign if1.probe_y = y1;

  logic [7:0] o_tab[2];
  logic [7:0] o_msk[2];
  logic [2:0] o_vec[2];
  logic       o_busy[2];
  logic       o_done[2];
  logic       o_mm[2];
  logic       i_start[2];
  logic [7:0] i_exp[2];

  assign o_tab[0] = if0.table_out;      assign o_tab[1] = if1.table_out;
  assign o_msk[0] = if0.mismatch_mask;  assign o_msk[1] = if1.mismatch_mask;
  assign o_vec[0] = {if0.probe_b, if0.probe_a, if0.probe_c};
  assign o_vec[1] = {if1.probe_b, if1.probe_a, if1.probe_c};
  assign o_busy[0] = if0.busy;          assign o_busy[1] = if1.busy;
  assign o_done[0] = if0.done;          assign o_done[1] = if1.done;
  assign o_mm[0] = if0.mismatch;        assign o_mm[1] = if1.mismatch;
  assign i_start[0] = if0.start;        assign i_start[1] = if1.start;
  assign i_exp[0] = if0.expected;       assign i_exp[1] = if1.expected;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int scfg(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic int dlen(input int d);
    return 8 * (scfg(d) + 1) + 1;
  endfunction

  // Truth table of the function wired to instance d, straight from its boolean definition.
  function automatic logic [7:0] golden(input int d, input int sel);
    logic [7:0] t;
    logic [2:0] v;
    logic a, b, c;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      b = v[2]; a = v[1]; c = v[0];
      if (d == 1)        t[i] = (b & ~c) | a;
      else if (sel == 0) t[i] = a & b;
      else if (sel == 1) t[i] = a ^ b;
      else               t[i] = 1'b0;
    end
    return t;
  endfunction

  // Model: k counts cycles since the accepting edge; done lands at k = 8*(S+1)+1.
  bit         m_act[2];
  int         m_k[2];
  logic [7:0] m_gold[2];
  logic [7:0] m_exp[2];
  logic [7:0] m_tab[2];
  logic [7:0] m_msk[2];

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d] <= 1'b0;
        m_k[d]   <= 0;
        m_tab[d] <= '0;
        m_msk[d] <= '0;
        m_exp[d] <= '0;
      end else if (!m_act[d]) begin
        if (i_start[d]) begin
          m_act[d]  <= 1'b1;
          m_k[d]    <= 1;
          m_tab[d]  <= '0;
          m_msk[d]  <= '0;
          m_exp[d]  <= i_exp[d];
          m_gold[d] <= golden(d, fsel);
        end
      end else if (m_k[d] == dlen(d)) begin
        m_act[d] <= 1'b0;
      end else begin
        m_k[d] <= m_k[d] + 1;
        if (m_k[d] + 1 == dlen(d)) begin
          m_tab[d] <= m_gold[d];
          m_msk[d] <= m_gold[d] ^ m_exp[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        if (m_act[d] && m_k[d] < dlen(d)) begin
          int n;
          logic [7:0] pm;
          n  = (m_k[d] - 1) / (scfg(d) + 1);
          pm = 8'((1 << n) - 1);
          check("vec", d, 32'(o_vec[d]), 32'(n));
          check("busy", d, 32'(o_busy[d]), 1);
          check("done", d, 32'(o_done[d]), 0);
          check("partial_table", d, 32'(o_tab[d]), 32'(m_gold[d] & pm));
        end else begin
          if (!m_act[d]) check("idle_vec", d, 32'(o_vec[d]), 0);
          check("busy", d, 32'(o_busy[d]), m_act[d] ? 1 : 0);
          check("done", d, 32'(o_done[d]), m_act[d] ? 1 : 0);
          check("table", d, 32'(o_tab[d]), 32'(m_tab[d]));
          check("mask", d, 32'(o_msk[d]), 32'(m_msk[d]));
          check("mismatch", d, 32'(o_mm[d]), (m_msk[d] != 0) ? 1 : 0);
        end
      end
    end
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) if0.start = v;
    else        if1.start = v;
  endtask

  task automatic sweep(input int d, input logic [7:0] ev, input int pa, input int pb,
                       output int dcyc, output int ndone);
    if (d == 0) if0.expected = ev;
    else        if1.expected = ev;
    set_start(d, 1'b1);
    @(posedge clk);
    dcyc  = -1;
    ndone = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      set_start(d, (k == pa) || (k == pb));
      if (o_done[d]) begin
        ndone++;
        if (dcyc < 0) dcyc = k;
      end
      if (dcyc > 0 && k >= dcyc + 2) break;
    end
    set_start(d, 1'b0);
    check("done_timeout", d, (dcyc < 0) ? 0 : 1, 1);
  endtask

  task automatic check_zero(input string nm, input int d);
    check({nm, "_busy"}, d, 32'(o_busy[d]), 0);
    check({nm, "_done"}, d, 32'(o_done[d]), 0);
    check({nm, "_table"}, d, 32'(o_tab[d]), 0);
    check({nm, "_mask"}, d, 32'(o_msk[d]), 0);
    check({nm, "_mismatch"}, d, 32'(o_mm[d]), 0);
    check({nm, "_vec"}, d, 32'(o_vec[d]), 0);
  endtask

  initial begin
    int dc, nd, d1, d2;
    reset = 1'b1;
    if0.start = 1'b0; if0.expected = '0;
    if1.start = 1'b0; if1.expected = '0;
    repeat (2) @(negedge clk);
    check_zero("reset", 0);
    check_zero("reset", 1);
    reset = 1'b0;
    @(negedge clk);

    fsel = 0;
    sweep(0, 8'hC0, 0, 0, dc, nd);
    check("and_done_cycle", 0, dc, 17);
    check("and_done_count", 0, nd, 1);
    check("and_table", 0, 32'(if0.table_out), 'hC0);
    check("and_mismatch", 0, 32'(if0.mismatch), 0);

    fsel = 1;
    sweep(0, 8'h3C, 0, 0, dc, nd);
    check("xor_table", 0, 32'(if0.table_out), 'h3C);
    check("xor_mask", 0, 32'(if0.mismatch_mask), 'h00);

    fsel = 2;
    sweep(0, 8'hFF, 0, 0, dc, nd);
    check("zero_table", 0, 32'(if0.table_out), 'h00);
    check("zero_mask", 0, 32'(if0.mismatch_mask), 'hFF);
    check("zero_mismatch", 0, 32'(if0.mismatch), 1);

    // Reset at cycle 7 of an XOR sweep: vectors 0..2 are already captured (table 0x04).
    fsel = 1;
    if0.expected = 8'h3C;
    if0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_table", 0, 32'(if0.table_out), 'h04);
    check("pre_reset_busy", 0, 32'(if0.busy), 1);
    #2 reset = 1'b1;
    #1 check_zero("midreset", 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sweep(0, 8'h3C, 0, 0, dc, nd);
    check("post_reset_done_cycle", 0, dc, 17);
    check("post_reset_table", 0, 32'(if0.table_out), 'h3C);
    check("post_reset_mask", 0, 32'(if0.mismatch_mask), 'h00);

    fsel = 0;
    sweep(0, 8'hC0, 5, 16, dc, nd);
    check("busy_start_done_cycle", 0, dc, 17);
    check("busy_start_done_count", 0, nd, 1);
    check("busy_start_table", 0, 32'(if0.table_out), 'hC0);

    // Start held through DONE: next sweep accepted at edge 18, its done at cycle 35.
    if0.expected = 8'hC0;
    if0.start = 1'b1;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (if0.done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 18) check("held_idle_busy", 0, 32'(if0.busy), 0);
      if (k == 19) begin
        check("held_rebusy", 0, 32'(if0.busy), 1);
        if0.start = 1'b0;
      end
      if (d2 > 0) break;
    end
    if0.start = 1'b0;
    check("held_first_done", 0, d1, 17);
    check("held_second_done", 0, d2, 35);
    repeat (3) @(negedge clk);

    sweep(1, 8'hDC, 0, 0, dc, nd);
    check("slow_done_cycle", 1, dc, 33);
    check("slow_table", 1, 32'(if1.table_out), 'hDC);
    check("slow_mismatch", 1, 32'(if1.mismatch), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
